// File: rtl/pwm_duty_sequencer_if.sv
// rtl/pwm_duty_sequencer_if.sv - register bus between the duty sequencer and the PWM register block
interface pwm_duty_sequencer_if;
    logic [7:0]  addr_o;
    logic [15:0] wdata_o;
    logic        write_o;
    logic        read_o;
    logic [15:0] rdata_i;

    modport master (
        output addr_o,
        output wdata_o,
        output write_o,
        output read_o,
        input  rdata_i
    );

    modport slave (
        input  addr_o,
        input  wdata_o,
        input  write_o,
        input  read_o,
        output rdata_i
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - writes table compare pairs to channel-1 on each overflow event
// Optional dead-time field and WR_DTG state enabled by macro PWM_SEQ_DTG_EN.
module pwm_duty_sequencer #(
    parameter int         WIDTH          = 16,
    parameter int         DEPTH          = 8,
    parameter logic [7:0] ADDR_CMP_START = 8'h10,
    parameter logic [7:0] ADDR_CMP_END   = 8'h12,
    parameter logic [7:0] ADDR_DTG       = 8'h14,
    localparam int        IW             = $clog2(DEPTH)
) (
    input  logic                 clk_psc_i,
    input  logic                 rst_i,
    input  logic [7:0]           host_addr_i,
    input  logic [15:0]          host_wdata_i,
    input  logic                 host_write_i,
    input  logic                 host_read_i,
    output logic [15:0]          host_rdata_o,
    output logic                 host_ready_o,
    input  logic                 tbl_wr_i,
    input  logic [IW-1:0]        tbl_idx_i,
    input  logic [WIDTH-1:0]     tbl_start_i,
    input  logic [WIDTH-1:0]     tbl_end_i,
`ifdef PWM_SEQ_DTG_EN
    input  logic [7:0]           tbl_dtg_i,
`endif
    input  logic                 seq_en_i,
    input  logic [IW:0]          seq_len_i,
    input  logic                 update_event_i,
    pwm_duty_sequencer_if.master bus,
    output logic                 busy_o,
    output logic [IW-1:0]        seq_idx_o,
    output logic                 wrap_o,
    output logic                 missed_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_START = 2'd1,
        S_WR_END   = 2'd2,
        S_WR_DTG   = 2'd3
    } state_t;

    state_t           r_state, w_next;
    logic [IW-1:0]    r_idx;
    logic             r_wrap;
    logic [WIDTH-1:0] r_tbl_start [DEPTH];
    logic [WIDTH-1:0] r_tbl_end   [DEPTH];
    logic [WIDTH-1:0] r_hold_start;
    logic [WIDTH-1:0] r_hold_end;
`ifdef PWM_SEQ_DTG_EN
    logic [7:0]       r_tbl_dtg   [DEPTH];
    logic [7:0]       r_hold_dtg;
`else
    wire              w_unused_dtg = ^ADDR_DTG;
`endif

    logic [IW:0] w_eff_len;
    logic [IW:0] w_idx_inc;
    logic        w_start_seq;
    logic        w_last;

    assign w_eff_len   = (seq_len_i > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : seq_len_i;
    assign w_idx_inc   = {1'b0, r_idx} + (IW+1)'(1);
    assign w_start_seq = (r_state == S_IDLE) && update_event_i && seq_en_i && (w_eff_len != '0);
`ifdef PWM_SEQ_DTG_EN
    assign w_last      = (r_state == S_WR_DTG);
`else
    assign w_last      = (r_state == S_WR_END);
`endif

    always_ff @(posedge clk_psc_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start_seq) w_next = S_WR_START;
            S_WR_START: w_next = S_WR_END;
`ifdef PWM_SEQ_DTG_EN
            S_WR_END:   w_next = S_WR_DTG;
            S_WR_DTG:   w_next = S_IDLE;
`else
            S_WR_END:   w_next = S_IDLE;
`endif
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.addr_o   = host_addr_i;
        bus.wdata_o  = host_wdata_i;
        bus.write_o  = host_write_i;
        bus.read_o   = host_read_i;
        host_ready_o = 1'b1;
        busy_o       = 1'b0;
        case (r_state)
            S_WR_START: begin
                bus.addr_o   = ADDR_CMP_START;
                bus.wdata_o  = 16'(r_hold_start);
                bus.write_o  = 1'b1;
                bus.read_o   = 1'b0;
                host_ready_o = 1'b0;
                busy_o       = 1'b1;
            end
            S_WR_END: begin
                bus.addr_o   = ADDR_CMP_END;
                bus.wdata_o  = 16'(r_hold_end);
                bus.write_o  = 1'b1;
                bus.read_o   = 1'b0;
                host_ready_o = 1'b0;
                busy_o       = 1'b1;
            end
`ifdef PWM_SEQ_DTG_EN
            S_WR_DTG: begin
                bus.addr_o   = ADDR_DTG;
                bus.wdata_o  = {8'h00, r_hold_dtg};
                bus.write_o  = 1'b1;
                bus.read_o   = 1'b0;
                host_ready_o = 1'b0;
                busy_o       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Table, holding registers and index; the index advance uses >= so a shrunken length forces a wrap.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            r_idx        <= '0;
            r_wrap       <= 1'b0;
            r_hold_start <= '0;
            r_hold_end   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl_start[i] <= '0;
                r_tbl_end[i]   <= '0;
`ifdef PWM_SEQ_DTG_EN
                r_tbl_dtg[i]   <= '0;
`endif
            end
`ifdef PWM_SEQ_DTG_EN
            r_hold_dtg   <= '0;
`endif
        end else begin
            r_wrap <= 1'b0;
            if (tbl_wr_i) begin
                r_tbl_start[tbl_idx_i] <= tbl_start_i;
                r_tbl_end[tbl_idx_i]   <= tbl_end_i;
`ifdef PWM_SEQ_DTG_EN
                r_tbl_dtg[tbl_idx_i]   <= tbl_dtg_i;
`endif
            end
            if (w_start_seq) begin
                r_hold_start <= r_tbl_start[r_idx];
                r_hold_end   <= r_tbl_end[r_idx];
`ifdef PWM_SEQ_DTG_EN
                r_hold_dtg   <= r_tbl_dtg[r_idx];
`endif
            end
            if (w_last) begin
                if (w_idx_inc >= w_eff_len) begin
                    r_idx  <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_idx  <= w_idx_inc[IW-1:0];
                end
            end else if (r_state == S_IDLE && !seq_en_i) begin
                r_idx <= '0;
            end
        end
    end

    assign host_rdata_o = bus.rdata_i;
    assign seq_idx_o    = r_idx;
    assign wrap_o       = r_wrap;
    assign missed_o     = update_event_i && (r_state != S_IDLE);

endmodule
